// File: rtl/any1_pkg.sv
// Shared types for the align stage: the align-to-decode record and the
// branch opcode prefix that the static predictor matches on.
package any1_pkg;

    localparam int unsigned AddrW   = 32;
    localparam int unsigned StreamW = 4;

    localparam logic [4:0] BrOpPrefix = 5'b01001;

    typedef logic [AddrW-1:0] Address;
    typedef logic [31:0]      Instruction;

    typedef struct packed {
        Address                ip;
        Instruction            ir;
        logic                  predict_taken;
        logic [StreamW-1:0]    stream;
    } sInstAlignOut;

endpackage

// File: rtl/any1_line_fifo.sv
// Small tag+data line buffer between the I-cache port and the aligner.
// Flush wins over push and pop; push into a full buffer needs a same-cycle pop.
module any1_line_fifo #(
    parameter int unsigned Lines = 2,
    parameter int unsigned TagW  = 28,
    parameter int unsigned DataW = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [TagW-1:0]         push_tag_i,
    input  logic [DataW-1:0]        push_dat_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output logic [$clog2(Lines):0]  count_o,
    output logic                    empty_o,
    output logic [TagW-1:0]         head_tag_o,
    output logic [DataW-1:0]        head_dat_o
);

    localparam int unsigned PtrW = $clog2(Lines);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [TagW-1:0]  tag_q [Lines];
    logic [DataW-1:0] dat_q [Lines];
    logic             full, do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full       = (count_q == CntW'(Lines));
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full || do_pop);
    assign count_o    = count_q;
    assign head_tag_o = tag_q[rd_ptr_q];
    assign head_dat_o = dat_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            tag_q[wr_ptr_q] <= push_tag_i;
            dat_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/any1_inst_align.sv
// Fetch-side aligner: requests 16-byte lines, buffers them and hands one
// instruction per cycle to decode, with static backward-taken prediction.
module any1_inst_align
    import any1_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   LINES    = 2,
    parameter logic [AW-1:0] RESET_IP = 32'hFFFC0000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          fetch_req_o,
    output logic [AW-1:0] fetch_adr_o,
    input  logic          fetch_ack_i,
    input  logic [127:0]  fetch_dat_i,
    input  logic          redirect_i,
    input  logic [AW-1:0] redirect_ip_i,
    output logic          a2d_valid_o,
    input  logic          a2d_ready_i,
    output sInstAlignOut  a2d_out_o
);

    localparam int unsigned TagW = AW - 4;
    localparam int unsigned CntW = $clog2(LINES) + 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StReq  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [AW-1:0]      ip_q, ip_d;
    logic [AW-1:0]      fa_q, fa_d;
    logic [StreamW-1:0] stream_q, stream_d;
    logic               discard_q, discard_d;

    logic [CntW-1:0]    count;
    logic               empty;
    logic [TagW-1:0]    head_tag;
    logic [127:0]       head_dat;

    logic [31:0]        ir;
    logic [AW-1:0]      disp, target;
    logic               predict, head_hit, stale, valid, handshake, taken;
    logic               ack_fire, push, pop, flush;

    any1_line_fifo #(
        .Lines (LINES),
        .TagW  (TagW),
        .DataW (128)
    ) u_line_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .push_tag_i (fa_q[AW-1:4]),
        .push_dat_i (fetch_dat_i),
        .pop_i      (pop),
        .flush_i    (flush),
        .count_o    (count),
        .empty_o    (empty),
        .head_tag_o (head_tag),
        .head_dat_o (head_dat)
    );

    always_comb begin
        ir = head_dat[31:0];
        case (ip_q[3:2])
            2'd1:    ir = head_dat[63:32];
            2'd2:    ir = head_dat[95:64];
            2'd3:    ir = head_dat[127:96];
            default: ir = head_dat[31:0];
        endcase
    end

    assign disp    = {{(AW-14){ir[31]}}, ir[31:26], ir[13:8], 2'b00};
    assign target  = ip_q + disp;
    assign predict = (ir[7:3] == BrOpPrefix) && disp[AW-1];

    assign head_hit  = !empty && (head_tag == ip_q[AW-1:4]);
    assign stale     = !empty && !head_hit;
    assign valid     = head_hit && !redirect_i;
    assign handshake = valid && a2d_ready_i;
    assign taken     = handshake && predict;

    assign ack_fire = (state_q == StReq) && fetch_ack_i;
    assign push     = ack_fire && !discard_q;
    assign flush    = redirect_i || taken;
    assign pop      = stale || (handshake && !predict && (ip_q[3:2] == 2'b11));

    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        fa_d      = fa_q;
        stream_d  = stream_q;
        discard_d = discard_q;

        case (state_q)
            StIdle: begin
                if ((count < CntW'(LINES)) && !redirect_i) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (fetch_ack_i) begin
                    state_d = StIdle;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        fa_d = fa_q + AW'(16);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A request still in flight when the stream changes returns a dead line.
        if (redirect_i) begin
            ip_d      = redirect_ip_i & ~AW'(3);
            fa_d      = redirect_ip_i & ~AW'(15);
            discard_d = (state_q == StReq) && !fetch_ack_i;
            stream_d  = stream_q + StreamW'(1);
        end else if (taken) begin
            ip_d      = target;
            fa_d      = target & ~AW'(15);
            discard_d = (state_q == StReq) && !fetch_ack_i;
            stream_d  = stream_q + StreamW'(1);
        end else if (handshake) begin
            ip_d = ip_q + AW'(4);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ip_q      <= RESET_IP;
            fa_q      <= RESET_IP;
            stream_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ip_q      <= ip_d;
            fa_q      <= fa_d;
            stream_q  <= stream_d;
            discard_q <= discard_d;
        end
    end

    assign fetch_req_o = (state_q == StReq);
    assign fetch_adr_o = fa_q;
    assign a2d_valid_o = valid;

    always_comb begin
        a2d_out_o = '0;
        if (valid) begin
            a2d_out_o.ip            = Address'(ip_q);
            a2d_out_o.ir            = ir;
            a2d_out_o.predict_taken = predict;
            a2d_out_o.stream        = stream_q;
        end
    end

endmodule

// File: tb/tb_any1_inst_align.sv
// Bench for the aligner: scoreboard of expected decode outputs, a table of
// predictor vectors, and hand-written sequences for buffering, redirect and reset.
`timescale 1ns/1ps
module tb_any1_inst_align;
    import any1_pkg::*;

    localparam int unsigned AW       = 32;
    localparam int unsigned LINES    = 2;
    localparam logic [31:0] RESET_IP = 32'hFFFC0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JUNK     = 32'hFC00_3C48;
    localparam logic [31:0] BR_BACK  = 32'hFC00_3C48;  // disp -16
    localparam logic [31:0] BR_FWD   = 32'h0000_0848;  // disp +32

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         fetch_req_o;
    logic [31:0]  fetch_adr_o;
    logic         fetch_ack_i = 1'b0;
    logic [127:0] fetch_dat_i = '0;
    logic         redirect_i = 1'b0;
    logic [31:0]  redirect_ip_i = '0;
    logic         a2d_valid_o;
    logic         a2d_ready_i = 1'b0;
    sInstAlignOut a2d_out_o;

    always #5 clk = ~clk;

    any1_inst_align #(
        .AW       (AW),
        .LINES    (LINES),
        .RESET_IP (RESET_IP)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .fetch_req_o   (fetch_req_o),
        .fetch_adr_o   (fetch_adr_o),
        .fetch_ack_i   (fetch_ack_i),
        .fetch_dat_i   (fetch_dat_i),
        .redirect_i    (redirect_i),
        .redirect_ip_i (redirect_ip_i),
        .a2d_valid_o   (a2d_valid_o),
        .a2d_ready_i   (a2d_ready_i),
        .a2d_out_o     (a2d_out_o)
    );

    int total = 0;
    int bad = 0;
    sInstAlignOut exp_q[$];
    sInstAlignOut mon_e;
    logic [StreamW-1:0] exp_stream = '0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] word;
        logic        taken;
    } row_t;
    row_t rows[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic sInstAlignOut mk(input logic [31:0] ip, input logic [31:0] ir,
                                        input logic tk, input logic [StreamW-1:0] st);
        sInstAlignOut e;
        e.ip = ip;
        e.ir = ir;
        e.predict_taken = tk;
        e.stream = st;
        return e;
    endfunction

    // Scoreboard: every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_ni && a2d_valid_o && a2d_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0h want none", a2d_out_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("a2d_out", a2d_out_o, mon_e);
            end
        end
    end

    task automatic wait_req(input string name, input logic [31:0] want, input bit chk_adr);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (fetch_req_o) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: got no request want request", name);
        end else if (chk_adr) begin
            check(name, fetch_adr_o, want);
        end
    endtask

    task automatic ack_line(input logic [127:0] d);
        @(posedge clk); #1;
        fetch_ack_i = 1'b1;
        fetch_dat_i = d;
        @(posedge clk); #1;
        fetch_ack_i = 1'b0;
        fetch_dat_i = '0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d outputs missing want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One-cycle redirect; a request in flight is answered with a line that must be dropped.
    task automatic do_redirect(input logic [31:0] tgt, output bit pend);
        @(posedge clk); #1;
        redirect_i = 1'b1;
        redirect_ip_i = tgt;
        @(negedge clk);
        pend = fetch_req_o;
        @(posedge clk); #1;
        redirect_i = 1'b0;
        exp_stream++;
        if (pend) begin
            wait_req("junk_req", '0, 1'b0);
            ack_line({4{JUNK}});
        end
    endtask

    initial begin
        bit           pend;
        logic [127:0] line;

        rows[0] = '{32'h4000_000C, 32'hFC00_3C48, 1'b1};
        rows[1] = '{32'h4000_001C, 32'h0000_0848, 1'b0};
        rows[2] = '{32'h4000_002F, 32'hFFFF_FF48, 1'b1};
        rows[3] = '{32'h4000_003C, 32'hFC00_3C40, 1'b0};
        rows[4] = '{32'h4000_004C, 32'hFC00_3C4F, 1'b1};
        rows[5] = '{32'h4000_005C, 32'h8000_0048, 1'b1};
        rows[6] = '{32'h4000_006C, 32'h7C00_FF48, 1'b0};
        rows[7] = '{32'h4000_007C, 32'hFC00_3C50, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req", fetch_req_o, 1'b0);
        check("rst_valid", a2d_valid_o, 1'b0);
        check("rst_out", a2d_out_o, '0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        check("rst_adr", fetch_adr_o, RESET_IP);

        // First line streams out back to back
        a2d_ready_i = 1'b1;
        wait_req("first_fetch", RESET_IP, 1'b1);
        exp_q.push_back(mk(32'hFFFC0000, 32'hA000_0013, 1'b0, exp_stream));
        exp_q.push_back(mk(32'hFFFC0004, 32'hB000_0023, 1'b0, exp_stream));
        exp_q.push_back(mk(32'hFFFC0008, 32'hC000_0033, 1'b0, exp_stream));
        exp_q.push_back(mk(32'hFFFC000C, 32'hD000_0043, 1'b0, exp_stream));
        ack_line({32'hD000_0043, 32'hC000_0033, 32'hB000_0023, 32'hA000_0013});
        wait_drain("line0_drain", 6);
        wait_req("next_fetch", 32'hFFFC0010, 1'b1);

        // Stall with the buffer filling up
        a2d_ready_i = 1'b0;
        ack_line({32'h1400_0413, 32'h1300_0313, 32'h1200_0213, 32'h1100_0113});
        wait_req("second_fetch", 32'hFFFC0020, 1'b1);
        ack_line({32'h2400_0413, 32'h2300_0313, 32'h2200_0213, 32'h2100_0113});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", a2d_valid_o, 1'b1);
            check("stall_out", a2d_out_o, mk(32'hFFFC0010, 32'h1100_0113, 1'b0, exp_stream));
            check("full_no_req", fetch_req_o, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(32'hFFFC0010 + 4 * i, 32'h1100_0113 + 32'h0100_0100 * i,
                               1'b0, exp_stream));
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(32'hFFFC0020 + 4 * i, 32'h2100_0113 + 32'h0100_0100 * i,
                               1'b0, exp_stream));
        end
        @(posedge clk); #1;
        a2d_ready_i = 1'b1;
        wait_drain("stall_drain", 14);

        // Redirect while a request is outstanding
        do_redirect(32'h0000_2006, pend);
        check("redirect_pending", pend, 1'b1);
        wait_req("redirect_fetch", 32'h0000_2000, 1'b1);
        exp_q.push_back(mk(32'h2004, 32'hE100_0013, 1'b0, exp_stream));
        exp_q.push_back(mk(32'h2008, 32'hE200_0013, 1'b0, exp_stream));
        exp_q.push_back(mk(32'h200C, 32'hE300_0013, 1'b0, exp_stream));
        ack_line({32'hE300_0013, 32'hE200_0013, 32'hE100_0013, 32'hE000_0013});
        wait_drain("redirect_drain", 8);

        // Backward branch in slot 2 is predicted taken
        do_redirect(32'h0000_1000, pend);
        wait_req("branch_fetch", 32'h0000_1000, 1'b1);
        exp_q.push_back(mk(32'h1000, 32'hC000_0013, 1'b0, exp_stream));
        exp_q.push_back(mk(32'h1004, 32'hC100_0013, 1'b0, exp_stream));
        exp_q.push_back(mk(32'h1008, BR_BACK, 1'b1, exp_stream));
        exp_stream++;
        ack_line({NOP, BR_BACK, 32'hC100_0013, 32'hC000_0013});
        wait_drain("branch_drain", 8);
        wait_req("stale_req", '0, 1'b0);
        ack_line({4{JUNK}});
        wait_req("taken_fetch", 32'h0000_0FF0, 1'b1);

        // Forward branch at the target is not taken
        exp_q.push_back(mk(32'h0FF8, BR_FWD, 1'b0, exp_stream));
        exp_q.push_back(mk(32'h0FFC, 32'hD300_0013, 1'b0, exp_stream));
        ack_line({32'hD300_0013, BR_FWD, NOP, NOP});
        wait_drain("fwd_drain", 8);

        // Predictor vectors, one redirect per row
        for (int i = 0; i < 8; i++) begin
            do_redirect(rows[i].adr, pend);
            wait_req("row_fetch", rows[i].adr & ~32'hF, 1'b1);
            line = {4{NOP}};
            line[32 * rows[i].adr[3:2] +: 32] = rows[i].word;
            exp_q.push_back(mk(rows[i].adr & ~32'h3, rows[i].word, rows[i].taken, exp_stream));
            if (rows[i].taken) exp_stream++;
            ack_line(line);
            wait_drain("row_drain", 8);
        end

        // Asynchronous reset mid-request with an instruction on offer
        do_redirect(32'h0000_1000, pend);
        wait_req("prereset_fetch", 32'h0000_1000, 1'b1);
        a2d_ready_i = 1'b0;
        ack_line({NOP, NOP, NOP, 32'hF000_0013});
        wait_req("prereset_next", 32'h0000_1010, 1'b1);
        check("prereset_valid", a2d_valid_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_req", fetch_req_o, 1'b0);
        check("async_valid", a2d_valid_o, 1'b0);
        check("async_out", a2d_out_o, '0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        check("rerst_adr", fetch_adr_o, RESET_IP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
